adc_packer: RTL

ADC_PACKER -- requirements
Module: adc_packer

---
 rtl/adc_packer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/adc_packer.sv
// ADC sample packer: quantises demuxed DDR samples, packs enabled channels
// LSB-first into OUT_W-bit words and queues them in an output FIFO.
module adc_packer #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned OUT_W      = 64,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [16*NCH-1:0]    in_data,
    input  logic                 in_valid,
    input  logic [1:0]           mode,
    input  logic [NCH-1:0]       ch_en,
    input  logic                 cfg_load,
    input  logic                 clr_stat,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overflow,
    output logic [15:0]          drop_count
);

    localparam int unsigned NEW_W  = 16 * NCH;
    localparam int unsigned ACC_W  = OUT_W + NEW_W;
    localparam int unsigned FILL_W = $clog2(ACC_W + 1);
    localparam int unsigned POS_W  = $clog2(NEW_W + 1);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;

    logic [1:0]             mode_q, mode_d;
    logic [NCH-1:0]         ch_en_q, ch_en_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [PTR_W-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [OUT_W-1:0]       out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overflow_q, overflow_d;
    logic [15:0]            drop_count_q, drop_count_d;
    logic [OUT_W-1:0]       mem_q [FIFO_DEPTH];

    logic [NEW_W-1:0]       new_bits;
    logic [POS_W-1:0]       pos;
    logic [POS_W-1:0]       bsz;
    logic [7:0]             smp;
    logic [7:0]             qv;
    logic                   accept;
    logic [FILL_W-1:0]      fill_sum;
    logic [ACC_W-1:0]       acc_sum;
    logic                   push_req;
    logic [OUT_W-1:0]       push_word;
    logic                   pop;
    logic                   full;
    logic                   push_ok;
    logic                   drop;
    logic [CNT_W-1:0]       remain;

    // Quantise each enabled channel's two samples and concatenate them densely.
    always_comb begin
        new_bits = '0;
        pos      = '0;
        smp      = '0;
        qv       = '0;
        case (mode_q)
            2'd1:    bsz = POS_W'(4);
            2'd2:    bsz = POS_W'(2);
            default: bsz = POS_W'(8);
        endcase
        for (int k = 0; k < int'(NCH); k++) begin
            for (int s = 0; s < 2; s++) begin
                smp = in_data[16*k+8*s +: 8];
                case (mode_q)
                    2'd1:    qv = {4'b0, smp[7:4]};
                    2'd2:    qv = {6'b0, smp[7:6]};
                    default: qv = smp;
                endcase
                if (ch_en_q[k]) begin
                    new_bits = new_bits | (NEW_W'(qv) << pos);
                    pos      = pos + bsz;
                end
            end
        end
    end

    // Accumulator append, word extraction and FIFO/status next state.
    always_comb begin
        accept    = in_valid && !cfg_load;
        fill_sum  = fill_q + (accept ? FILL_W'(pos) : '0);
        acc_sum   = acc_q | (accept ? (ACC_W'(new_bits) << fill_q) : '0);
        push_req  = fill_sum >= FILL_W'(OUT_W);
        push_word = acc_sum[OUT_W-1:0];

        mode_d  = mode_q;
        ch_en_d = ch_en_q;
        acc_d   = push_req ? (acc_sum >> OUT_W) : acc_sum;
        fill_d  = push_req ? (fill_sum - FILL_W'(OUT_W)) : fill_sum;
        if (cfg_load) begin
            mode_d  = mode;
            ch_en_d = ch_en;
            acc_d   = '0;
            fill_d  = '0;
        end

        pop     = out_valid_q && out_ready;
        full    = count_q == CNT_W'(FIFO_DEPTH);
        push_ok = push_req && (!full || pop);
        drop    = push_req && full && !pop;
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        remain  = count_q - CNT_W'(pop);
        wptr_d  = push_ok ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + PTR_W'(1) : rptr_q;

        // Head register follows the entry that will be at the read pointer.
        if (push_ok && remain == '0) begin
            out_data_d = push_word;
        end else if (count_d == '0) begin
            out_data_d = '0;
        end else begin
            out_data_d = mem_q[rptr_d];
        end
        out_valid_d = count_d != '0;

        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (drop) begin
            overflow_d   = 1'b1;
            drop_count_d = clr_stat ? 16'd1
                         : (drop_count_q == 16'hFFFF ? drop_count_q : drop_count_q + 16'd1);
        end else if (clr_stat) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= 2'd0;
            ch_en_q      <= '1;
            acc_q        <= '0;
            fill_q       <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            mode_q       <= mode_d;
            ch_en_q      <= ch_en_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage array needs no reset; pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[wptr_q] <= push_word;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule
